mvu_job_ctrl: RTL and testbench

- Per-MVU job sequencer. It drives the control and address side of one MVU core: weight read address, input-port reads, accumulator and quantizer strobes, and output data-bank writes.
- It is the initiator for the inputs the core consumes; the core is the responder.
- It turns one latched job configuration into a cycle-accurate issue stream.
- One instance sits per MVU in front of the core array, fed by the config registers.

---
 rtl/mvu_pkg.sv | 23 ++
 rtl/mvu_agu.sv | 93 +++++++++
 rtl/mvu_job_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mvu_job_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared widths, FSM encoding and config helpers for the MVU job sequencer.
package mvu_pkg;

    localparam int BWBANKA = 9;
    localparam int BDBANKA = 15;
    localparam int BCNTDWN = 29;
    localparam int BPREC   = 6;
    localparam int BCFG    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_QUANT,
        S_WRITE
    } job_state_e;

    // A programmed loop length of 0 behaves as a single-iteration loop.
    function automatic logic [BCFG-1:0] eff_len(input logic [BCFG-1:0] len);
        return (len == '0) ? BCFG'(1) : len;
    endfunction

endpackage

// File: rtl/mvu_agu.sv
// Two-level strided address generator; addr is the address for the current issue.
// Config is captured on load; one step per issue, no internal backpressure.
module mvu_agu
    import mvu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [BCFG-1:0] base,
    input  logic [BCFG-1:0] stride_0,
    input  logic [BCFG-1:0] stride_1,
    input  logic [BCFG-1:0] length_0,
    input  logic [BCFG-1:0] length_1,
    output logic [BCFG-1:0] addr,
    output logic            inner_zero
);

    logic [BCFG-1:0] base_q, base_d;
    logic [BCFG-1:0] str0_q, str0_d;
    logic [BCFG-1:0] str1_q, str1_d;
    logic [BCFG-1:0] len0_q, len0_d;
    logic [BCFG-1:0] len1_q, len1_d;
    logic [BCFG-1:0] addr_q, addr_d;
    logic [BCFG-1:0] inner_q, inner_d;
    logic [BCFG-1:0] outer_q, outer_d;
    logic [BCFG-1:0] inner_inc;
    logic [BCFG-1:0] outer_inc;

    always_comb begin
        base_d    = base_q;
        str0_d    = str0_q;
        str1_d    = str1_q;
        len0_d    = len0_q;
        len1_d    = len1_q;
        addr_d    = addr_q;
        inner_d   = inner_q;
        outer_d   = outer_q;
        inner_inc = inner_q + BCFG'(1);
        outer_inc = outer_q + BCFG'(1);

        if (load) begin
            base_d  = base;
            str0_d  = stride_0;
            str1_d  = stride_1;
            len0_d  = eff_len(length_0);
            len1_d  = eff_len(length_1);
            addr_d  = base;
            inner_d = '0;
            outer_d = '0;
        end else if (step) begin
            if (inner_inc == len0_q) begin
                inner_d = '0;
                if (outer_inc == len1_q) begin
                    outer_d = '0;
                    addr_d  = base_q;
                end else begin
                    outer_d = outer_inc;
                    addr_d  = addr_q + str1_q;
                end
            end else begin
                inner_d = inner_inc;
                addr_d  = addr_q + str0_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            str0_q  <= '0;
            str1_q  <= '0;
            len0_q  <= '0;
            len1_q  <= '0;
            addr_q  <= '0;
            inner_q <= '0;
            outer_q <= '0;
        end else begin
            base_q  <= base_d;
            str0_q  <= str0_d;
            str1_q  <= str1_d;
            len0_q  <= len0_d;
            len1_q  <= len1_d;
            addr_q  <= addr_d;
            inner_q <= inner_d;
            outer_q <= outer_d;
        end
    end

    assign addr       = addr_q;
    assign inner_zero = (inner_q == '0);

endmodule

// File: rtl/mvu_job_ctrl.sv
// Per-MVU job sequencer: one latched config -> read issue, drain, quantize, bit-plane writes.
// Quant strobe PIPE_LAT cycles after the last issue; reads stall on rdi_grnt, writes on wrd_grnt.
module mvu_job_ctrl
    import mvu_pkg::*;
#(
    parameter int PIPE_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic [BCNTDWN-1:0] countdown,
    input  logic [BPREC-1:0]   oprecision,
    input  logic [BCFG-1:0]    wbaseaddr,
    input  logic [BCFG-1:0]    ibaseaddr,
    input  logic [BCFG-1:0]    obaseaddr,
    input  logic [BCFG-1:0]    wstride_0,
    input  logic [BCFG-1:0]    wstride_1,
    input  logic [BCFG-1:0]    istride_0,
    input  logic [BCFG-1:0]    istride_1,
    input  logic [BCFG-1:0]    ostride_0,
    input  logic [BCFG-1:0]    wlength_0,
    input  logic [BCFG-1:0]    wlength_1,
    input  logic [BCFG-1:0]    ilength_0,
    input  logic [BCFG-1:0]    ilength_1,
    output logic [BWBANKA-1:0] rdw_addr,
    output logic               rdi_en,
    input  logic               rdi_grnt,
    output logic [BDBANKA-1:0] rdi_addr,
    output logic               acc_clr,
    output logic               acc_sh,
    output logic               quant_start,
    output logic               wrd_en,
    input  logic               wrd_grnt,
    output logic [BDBANKA-1:0] wrd_addr
);

    localparam int DCW = 8;

    job_state_e         state_q, state_d;
    logic [BCNTDWN-1:0] remaining_q, remaining_d;
    logic               first_q, first_d;
    logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
    logic [BPREC-1:0]   oprec_q, oprec_d;
    logic [BCFG-1:0]    obase_q, obase_d;
    logic [BCFG-1:0]    ostride_q, ostride_d;
    logic [BPREC-1:0]   k_q, k_d;
    logic [BCFG-1:0]    wr_addr_q, wr_addr_d;
    logic               done_q, done_d;

    logic               agu_load;
    logic               issue;
    logic [BCFG-1:0]    w_addr;
    logic [BCFG-1:0]    i_addr;
    logic               w_inner_zero;
    logic               i_inner_zero;

    assign agu_load = (state_q == S_IDLE) && start;
    assign issue    = (state_q == S_RUN) && rdi_grnt;

    mvu_agu u_wagu (
        .clk        (clk),
        .rst        (rst),
        .load       (agu_load),
        .step       (issue),
        .base       (wbaseaddr),
        .stride_0   (wstride_0),
        .stride_1   (wstride_1),
        .length_0   (wlength_0),
        .length_1   (wlength_1),
        .addr       (w_addr),
        .inner_zero (w_inner_zero)
    );

    mvu_agu u_iagu (
        .clk        (clk),
        .rst        (rst),
        .load       (agu_load),
        .step       (issue),
        .base       (ibaseaddr),
        .stride_0   (istride_0),
        .stride_1   (istride_1),
        .length_0   (ilength_0),
        .length_1   (ilength_1),
        .addr       (i_addr),
        .inner_zero (i_inner_zero)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        first_d     = first_q;
        drain_cnt_d = drain_cnt_q;
        oprec_d     = oprec_q;
        obase_d     = obase_q;
        ostride_d   = ostride_q;
        k_d         = k_q;
        wr_addr_d   = wr_addr_q;
        done_d      = 1'b0;
        busy        = (state_q != S_IDLE);
        rdi_en      = 1'b0;
        acc_clr     = 1'b0;
        acc_sh      = 1'b0;
        quant_start = 1'b0;
        wrd_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = countdown;
                    first_d     = 1'b1;
                    oprec_d     = oprecision;
                    obase_d     = obaseaddr;
                    ostride_d   = ostride_0;
                    if (countdown == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rdi_en  = 1'b1;
                acc_clr = first_q;
                acc_sh  = w_inner_zero && !first_q;
                if (rdi_grnt) begin
                    remaining_d = remaining_q - BCNTDWN'(1);
                    first_d     = 1'b0;
                    if (remaining_q == BCNTDWN'(1)) begin
                        drain_cnt_d = DCW'(1);
                        state_d     = (PIPE_LAT > 1) ? S_DRAIN : S_QUANT;
                    end
                end
            end
            S_DRAIN: begin
                // The QUANT cycle itself is the PIPE_LAT-th cycle after the last issue.
                if (drain_cnt_q >= DCW'(PIPE_LAT - 1)) begin
                    state_d = S_QUANT;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            S_QUANT: begin
                quant_start = 1'b1;
                k_d         = '0;
                wr_addr_d   = obase_q;
                if (oprec_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                wrd_en = 1'b1;
                if (wrd_grnt) begin
                    k_d       = k_q + BPREC'(1);
                    wr_addr_d = wr_addr_q + ostride_q;
                    if (k_q + BPREC'(1) == oprec_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            first_q     <= 1'b0;
            drain_cnt_q <= '0;
            oprec_q     <= '0;
            obase_q     <= '0;
            ostride_q   <= '0;
            k_q         <= '0;
            wr_addr_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
            drain_cnt_q <= drain_cnt_d;
            oprec_q     <= oprec_d;
            obase_q     <= obase_d;
            ostride_q   <= ostride_d;
            k_q         <= k_d;
            wr_addr_q   <= wr_addr_d;
            done_q      <= done_d;
        end
    end

    assign done     = done_q;
    assign rdw_addr = w_addr[BWBANKA-1:0];
    assign rdi_addr = i_addr[BDBANKA-1:0];
    assign wrd_addr = wr_addr_q[BDBANKA-1:0];

    // Address math runs at full config width; only the bank-address bits leave the block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{w_addr[BCFG-1:BWBANKA], i_addr[BCFG-1:BDBANKA],
                                wr_addr_q[BCFG-1:BDBANKA], i_inner_zero};

endmodule

// File: tb/tb_mvu_job_ctrl.sv
// Directed bench for mvu_job_ctrl: issue stream, stalls, drain latency, writes, zero cases, reset.
module tb_mvu_job_ctrl;
    import mvu_pkg::*;

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic [BCNTDWN-1:0] countdown;
    logic [BPREC-1:0]   oprecision;
    logic [BCFG-1:0]    wbaseaddr, ibaseaddr, obaseaddr;
    logic [BCFG-1:0]    wstride_0, wstride_1, istride_0, istride_1, ostride_0;
    logic [BCFG-1:0]    wlength_0, wlength_1, ilength_0, ilength_1;
    logic [BWBANKA-1:0] rdw_addr;
    logic               rdi_en;
    logic               rdi_grnt;
    logic [BDBANKA-1:0] rdi_addr;
    logic               acc_clr;
    logic               acc_sh;
    logic               quant_start;
    logic               wrd_en;
    logic               wrd_grnt;
    logic [BDBANKA-1:0] wrd_addr;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed issue stream for the basic job (w: 2x2 loop, i: length_0=0, stride_1=-16).
    logic [31:0] exp_w   [4] = '{32'h010, 32'h011, 32'h019, 32'h01a};
    logic [31:0] exp_i   [4] = '{32'h200, 32'h1f0, 32'h1e0, 32'h200};
    logic [31:0] exp_clr [4] = '{32'd1, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp_sh  [4] = '{32'd0, 32'd0, 32'd1, 32'd0};

    mvu_job_ctrl #(.PIPE_LAT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .countdown   (countdown),
        .oprecision  (oprecision),
        .wbaseaddr   (wbaseaddr),
        .ibaseaddr   (ibaseaddr),
        .obaseaddr   (obaseaddr),
        .wstride_0   (wstride_0),
        .wstride_1   (wstride_1),
        .istride_0   (istride_0),
        .istride_1   (istride_1),
        .ostride_0   (ostride_0),
        .wlength_0   (wlength_0),
        .wlength_1   (wlength_1),
        .ilength_0   (ilength_0),
        .ilength_1   (ilength_1),
        .rdw_addr    (rdw_addr),
        .rdi_en      (rdi_en),
        .rdi_grnt    (rdi_grnt),
        .rdi_addr    (rdi_addr),
        .acc_clr     (acc_clr),
        .acc_sh      (acc_sh),
        .quant_start (quant_start),
        .wrd_en      (wrd_en),
        .wrd_grnt    (wrd_grnt),
        .wrd_addr    (wrd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_basic();
        countdown  = 29'd4;
        wbaseaddr  = 32'h10;
        wstride_0  = 32'd1;
        wlength_0  = 32'd2;
        wstride_1  = 32'd8;
        wlength_1  = 32'd2;
        ibaseaddr  = 32'h200;
        istride_0  = 32'd4;
        ilength_0  = 32'd0;
        istride_1  = 32'hffff_fff0;
        ilength_1  = 32'd3;
        oprecision = 6'd1;
        obaseaddr  = 32'h40;
        ostride_0  = 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdi_en"}, rdi_en, 0);
        chk({tag, "_acc_clr"}, acc_clr, 0);
        chk({tag, "_acc_sh"}, acc_sh, 0);
        chk({tag, "_quant"}, quant_start, 0);
        chk({tag, "_wrd_en"}, wrd_en, 0);
        chk({tag, "_rdw_addr"}, rdw_addr, 0);
        chk({tag, "_rdi_addr"}, rdi_addr, 0);
        chk({tag, "_wrd_addr"}, wrd_addr, 0);
    endtask

    // Called at the first RUN cycle; leaves the bench at the first cycle after the last issue.
    task automatic run_issue(input int stall_idx, input int stall_len, input bit hold_start,
                             input int exp_cycles);
        int issued = 0;
        int stalled = 0;
        int cycles = 0;
        while (issued < 4 && cycles < 40) begin
            chk("rdi_en", rdi_en, 1);
            chk("busy_run", busy, 1);
            chk("rdw_addr", rdw_addr, exp_w[issued]);
            chk("rdi_addr", rdi_addr, exp_i[issued]);
            chk("acc_clr", acc_clr, exp_clr[issued]);
            chk("acc_sh", acc_sh, exp_sh[issued]);
            if (issued == stall_idx && stalled < stall_len) begin
                rdi_grnt = 1'b0;
                stalled++;
            end else begin
                rdi_grnt = 1'b1;
                issued++;
            end
            start = hold_start;
            tick();
            cycles++;
        end
        rdi_grnt = 1'b1;
        start    = 1'b0;
        chk("run_cycles", cycles, exp_cycles);
        chk("drain_rdi_en", rdi_en, 0);
        chk("drain_busy", busy, 1);
        chk("drain_rdw_reload", rdw_addr, exp_w[0]);
    endtask

    // Leaves the bench at the cycle after QUANT.
    task automatic wait_quant();
        int lat = 1;
        bit strobe = 1'b0;
        while (!quant_start && lat < 20) begin
            if (rdi_en || acc_clr || acc_sh || wrd_en || done) strobe = 1'b1;
            tick();
            lat++;
        end
        chk("quant_lat", lat, 4);
        chk("drain_strobes", strobe, 0);
        tick();
        chk("quant_once", quant_start, 0);
    endtask

    // Leaves the bench at the done cycle.
    task automatic run_write(input int n, input int stall_word, input int stall_len,
                             input logic [31:0] base, input logic [31:0] stride);
        int k = 0;
        int stalled = 0;
        int cycles = 0;
        logic [31:0] a;
        while (k < n && cycles < 40) begin
            a = (base + k * stride) & 32'h7fff;
            chk("wrd_en", wrd_en, 1);
            chk("wrd_addr", wrd_addr, a);
            chk("write_done_low", done, 0);
            if (k == stall_word && stalled < stall_len) begin
                wrd_grnt = 1'b0;
                stalled++;
            end else begin
                wrd_grnt = 1'b1;
                k++;
            end
            tick();
            cycles++;
        end
        wrd_grnt = 1'b1;
        chk("write_cycles", cycles, n + stall_len);
        chk("done_pulse", done, 1);
        chk("busy_fall", busy, 0);
        chk("wrd_en_off", wrd_en, 0);
    endtask

    task automatic finish_idle();
        tick();
        chk("done_single", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        rdi_grnt = 1'b1;
        wrd_grnt = 1'b1;
        set_basic();
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Basic job, single output word.
        set_basic();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_issue(-1, 0, 1'b0, 4);
        wait_quant();
        run_write(1, -1, 0, 32'h40, 32'h0);
        finish_idle();

        // Grant stall on issue 1 for 3 cycles.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_issue(1, 3, 1'b0, 7);
        wait_quant();
        run_write(1, -1, 0, 32'h40, 32'h0);

        // Restart in the done cycle; start held and config scrambled during the job.
        oprecision = 6'd3;
        obaseaddr  = 32'h100;
        ostride_0  = 32'h20;
        start = 1'b1;
        tick();
        countdown  = 29'd2;
        wbaseaddr  = 32'h77;
        ibaseaddr  = 32'h0;
        wstride_0  = 32'd5;
        ilength_1  = 32'd7;
        oprecision = 6'd5;
        obaseaddr  = 32'h0;
        ostride_0  = 32'd1;
        run_issue(-1, 0, 1'b1, 4);
        wait_quant();
        run_write(3, 1, 2, 32'h100, 32'h20);
        finish_idle();

        // countdown == 0: immediate done, nothing issued.
        set_basic();
        countdown = 29'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("cd0_done", done, 1);
        chk("cd0_busy", busy, 0);
        chk("cd0_rdi_en", rdi_en, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rdi_en || quant_start || wrd_en || busy || done) seen = 1'b1;
        end
        chk("cd0_quiet", seen, 0);

        // oprecision == 0: done straight after QUANT.
        set_basic();
        oprecision = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_issue(-1, 0, 1'b0, 4);
        wait_quant();
        run_write(0, -1, 0, 32'h0, 32'h0);
        finish_idle();

        // Reset during WRITE, then a fresh job.
        set_basic();
        oprecision = 6'd3;
        obaseaddr  = 32'h100;
        ostride_0  = 32'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_issue(-1, 0, 1'b0, 4);
        wait_quant();
        chk("prerst_wrd_en", wrd_en, 1);
        wrd_grnt = 1'b0;
        tick();
        chk("prerst_wrd_addr", wrd_addr, 32'h100);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        wrd_grnt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || busy || wrd_en) seen = 1'b1;
        end
        chk("postrst_quiet", seen, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_issue(-1, 0, 1'b0, 4);
        wait_quant();
        run_write(3, -1, 0, 32'h100, 32'h20);
        finish_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
